// File: rtl/cra_seq.sv
// Microcode address sequencer: builds the next CRAM address from J, skip,
// dispatch and a call/return stack, and registers it as craAddr.
module cra_seq #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 16,
  parameter int DISP_W      = 4
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             stall,
  input  logic [ADDR_W-1:0]                j,
  input  logic                             skipEn,
  input  logic                             skipCond,
  input  logic                             dispEn,
  input  logic [DISP_W-1:0]                dispIn,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             force1777,
  output logic [ADDR_W-1:0]                craAddr,
  output logic [$clog2(STACK_DEPTH):0]     stackDepth,
  output logic                             stackOvf,
  output logic                             stackUnf
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [ADDR_W-1:0] FORCE_ADDR = ADDR_W'(11'h3FF);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              stack_we;
  logic [AW-1:0]     stack_wa;
  logic [ADDR_W-1:0] stack_wd;

  logic [AW-1:0]     top_idx;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] nxt;
  logic              empty;
  logic              full;

  always_comb begin
    empty    = (depth_q == '0);
    full     = (depth_q == DW'(STACK_DEPTH));
    // At depth == STACK_DEPTH the low bits wrap to 0, so minus one still hits the last entry.
    top_idx  = depth_q[AW-1:0] - AW'(1);
    top      = stack_q[top_idx];

    addr_d   = addr_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stack_we = 1'b0;
    stack_wa = depth_q[AW-1:0];
    stack_wd = addr_q;

    nxt = j;
    if (ret && !empty) nxt = top | j;
    if (skipEn && skipCond) nxt[0] = 1'b1;
    if (dispEn) nxt[DISP_W-1:0] = nxt[DISP_W-1:0] | dispIn;

    if (force1777) begin
      addr_d  = FORCE_ADDR;
      depth_d = '0;
    end else if (!stall) begin
      addr_d = nxt;
      if (call && ret) begin
        stack_we = 1'b1;
        if (!empty) begin
          stack_wa = top_idx;
        end else begin
          depth_d = DW'(1);
          unf_d   = 1'b1;
        end
      end else if (call) begin
        if (!full) begin
          stack_we = 1'b1;
          depth_d  = depth_q + DW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (ret) begin
        if (!empty) depth_d = depth_q - DW'(1);
        else        unf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents need no reset: entries at or above depth_q are never read.
  always_ff @(posedge clk) begin
    if (stack_we) stack_q[stack_wa] <= stack_wd;
  end

  assign craAddr    = addr_q;
  assign stackDepth = depth_q;
  assign stackOvf   = ovf_q;
  assign stackUnf   = unf_q;

endmodule

// File: tb/tb_cra_seq.sv
// Bench for cra_seq: directed vectors, a queue-based reference model checked
// every cycle, plus literal expectations at key points.
module tb_cra_seq;

  localparam int ADDR_W      = 11;
  localparam int STACK_DEPTH = 16;
  localparam int DISP_W      = 4;

  logic                 clk;
  logic                 resetN;
  logic                 stall;
  logic [ADDR_W-1:0]    j;
  logic                 skipEn;
  logic                 skipCond;
  logic                 dispEn;
  logic [DISP_W-1:0]    dispIn;
  logic                 call;
  logic                 ret;
  logic                 force1777;
  logic [ADDR_W-1:0]    craAddr;
  logic [4:0]           stackDepth;
  logic                 stackOvf;
  logic                 stackUnf;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  cra_seq #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .DISP_W(DISP_W)) dut (
    .clk(clk), .resetN(resetN), .stall(stall), .j(j),
    .skipEn(skipEn), .skipCond(skipCond), .dispEn(dispEn), .dispIn(dispIn),
    .call(call), .ret(ret), .force1777(force1777),
    .craAddr(craAddr), .stackDepth(stackDepth),
    .stackOvf(stackOvf), .stackUnf(stackUnf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (actual running, required done)");
    $fatal(1, "timeout");
  end

  // reference model
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] m_stack[$];
  bit                m_ovf, m_unf;

  always @(posedge clk or negedge resetN) begin
    logic [ADDR_W-1:0] n;
    if (!resetN) begin
      m_addr = '0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (force1777) begin
      m_addr = 11'o1777;
      m_stack.delete();
    end else if (!stall) begin
      n = j;
      if (ret && m_stack.size() > 0) n = m_stack[$] | j;
      if (skipEn && skipCond) n = n | 11'd1;
      if (dispEn) n = n | {7'd0, dispIn};
      if (call && ret) begin
        if (m_stack.size() > 0) m_stack[m_stack.size()-1] = m_addr;
        else begin
          m_stack.push_back(m_addr);
          m_unf = 1;
        end
      end else if (call) begin
        if (m_stack.size() < STACK_DEPTH) m_stack.push_back(m_addr);
        else m_ovf = 1;
      end else if (ret) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else m_unf = 1;
      end
      m_addr = n;
    end
  end

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_addr",  32'(craAddr),    32'(m_addr));
      chk("model_depth", 32'(stackDepth), 32'(m_stack.size()));
      chk("model_ovf",   32'(stackOvf),   32'(m_ovf));
      chk("model_unf",   32'(stackUnf),   32'(m_unf));
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic op(input logic [ADDR_W-1:0] jv, input logic c, input logic r);
    j = jv; call = c; ret = r;
    cyc();
    call = 0; ret = 0;
  endtask

  task automatic lit(input string name, input logic [ADDR_W-1:0] a, input int d,
                     input logic o, input logic u);
    chk({name, "_addr"},  32'(craAddr),    32'(a));
    chk({name, "_depth"}, 32'(stackDepth), 32'(d));
    chk({name, "_ovf"},   32'(stackOvf),   32'(o));
    chk({name, "_unf"},   32'(stackUnf),   32'(u));
  endtask

  initial begin
    resetN = 0; stall = 0; j = '0; skipEn = 0; skipCond = 0;
    dispEn = 0; dispIn = '0; call = 0; ret = 0; force1777 = 0;
    repeat (3) cyc();
    cmp_en = 1;
    lit("reset", 11'o0, 0, 0, 0);
    resetN = 1;

    // linear flow
    op(11'o0100, 0, 0); lit("lin1", 11'o0100, 0, 0, 0);
    op(11'o0200, 0, 0); lit("lin2", 11'o0200, 0, 0, 0);

    // skip + dispatch: 0100 | 0110b | 1 = 0107
    skipEn = 1; skipCond = 1; dispEn = 1; dispIn = 4'b0110;
    op(11'o0100, 0, 0); lit("skipdisp", 11'o0107, 0, 0, 0);
    skipCond = 0;
    op(11'o0100, 0, 0); lit("disponly", 11'o0106, 0, 0, 0);
    skipEn = 0; dispEn = 0; dispIn = '0;

    // call / return
    op(11'o0300, 0, 0);
    op(11'o0500, 1, 0); lit("call", 11'o0500, 1, 0, 0);
    op(11'o0001, 0, 1); lit("ret", 11'o0301, 0, 0, 0);

    // fill past full
    for (int i = 0; i < 17; i++) op(11'(11'o1000 + i * 8), 1, 0);
    lit("full", 11'o1200, 16, 1, 0);
    for (int i = 0; i < 16; i++) op(11'o0, 0, 1);
    lit("drained", 11'o0301, 0, 1, 0);
    op(11'o0042, 0, 1); lit("underflow", 11'o0042, 0, 1, 1);

    // simultaneous call and ret
    op(11'o0100, 0, 0);
    op(11'o0400, 1, 0);
    op(11'o0250, 1, 0); lit("pre_swap", 11'o0250, 2, 1, 1);
    op(11'o0000, 1, 1); lit("swap", 11'o0400, 2, 1, 1);
    op(11'o0000, 0, 1); lit("swap_top", 11'o0250, 1, 1, 1);
    op(11'o0000, 0, 1); lit("swap_bot", 11'o0100, 0, 1, 1);

    // asynchronous reset mid-cycle
    call = 1; j = 11'o0700;
    resetN = 0; #2;
    lit("async_rst", 11'o0, 0, 0, 0);
    resetN = 1; call = 0;
    cyc();

    // call+ret on an empty stack acts as call and flags underflow
    op(11'o0123, 1, 1); lit("empty_swap", 11'o0123, 1, 0, 1);
    op(11'o0010, 1, 0);
    op(11'o0020, 1, 0); lit("depth3", 11'o0020, 3, 0, 1);

    // force1777 under stall
    stall = 1; force1777 = 1;
    op(11'o0005, 1, 0); lit("force", 11'o1777, 0, 0, 1);
    force1777 = 0;
    for (int i = 0; i < 5; i++) begin
      j = 11'(i * 3 + 7);
      cyc();
      chk("stall_hold", 32'(craAddr), 32'(11'o1777));
    end
    stall = 0;

    // stall holds a non-empty stack
    op(11'o0077, 1, 0);
    stall = 1;
    op(11'o0011, 1, 1); op(11'o0022, 0, 1);
    lit("stall_stack", 11'o0077, 1, 0, 1);
    stall = 0;
    op(11'o0001, 0, 1); lit("post_stall", 11'o1777, 0, 0, 1);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
